// File: rtl/bcd_entry_to_bin.sv
// Keypad-style decimal entry: synchronized push-buttons build a BCD number digit by digit
// and publish its binary value on completion (digit limit or finish), with error trapping.
module bcd_entry_to_bin #(
    parameter int N       = 10,
    parameter int MAX_DIG = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   digit_in,
    input  logic         enter,
    input  logic         finish,
    input  logic         clear,
    output logic [N-1:0] A,
    output logic         valid,
    output logic         err,
    output logic [1:0]   dig_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    localparam logic [1:0] LAST_CNT = 2'(MAX_DIG - 1);
    localparam logic [1:0] FULL_CNT = 2'(MAX_DIG);

    localparam int BTN_EN = 0;
    localparam int BTN_FI = 1;
    localparam int BTN_CL = 2;

    // Shift-and-add multiply by ten, then append the new digit, all at N bits.
    function automatic logic [N-1:0] mul10_add(input logic [N-1:0] x, input logic [3:0] d);
        logic [N-1:0] x8;
        logic [N-1:0] x2;
        x8 = x << 3;
        x2 = x << 1;
        return x8 + x2 + N'(d);
    endfunction

    logic [2:0] btn;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] prev_q;
    logic [1:0] warm_q;
    logic [2:0] ev;

    assign btn = {clear, finish, enter};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
            warm_q  <= 2'd0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    // Edges are masked until the pipeline has refilled, so a button held through reset is not an event.
    assign ev = sync2_q & ~prev_q & {3{warm_q == 2'd3}};

    logic [1:0]   state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] a_q, a_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic [N-1:0] acc_next;

    assign acc_next = mul10_add(acc_q, digit_in);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (ev[BTN_CL]) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = 2'd0;
        end else if (ev[BTN_EN]) begin
            if (state_q != ERROR) begin
                if (digit_in > 4'd9) begin
                    state_d = ERROR;
                end else if (state_q == ACCUM) begin
                    acc_d = acc_next;
                    if (cnt_q < LAST_CNT) begin
                        cnt_d = cnt_q + 2'd1;
                    end else begin
                        state_d = DONE;
                        a_d     = acc_next;
                        cnt_d   = FULL_CNT;
                        valid_d = 1'b1;
                    end
                end else begin
                    state_d = ACCUM;
                    acc_d   = N'(digit_in);
                    cnt_d   = 2'd1;
                end
            end
        end else if (ev[BTN_FI]) begin
            if (state_q == ACCUM) begin
                state_d = DONE;
                a_d     = acc_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign A       = a_q;
    assign valid   = valid_q;
    assign err     = (state_q == ERROR);
    assign dig_cnt = cnt_q;

endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// Bench for bcd_entry_to_bin: a digit-list model of the entry is compared every cycle,
// with literal expectations at key points of each scenario.
module tb_bcd_entry_to_bin;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] digit_in;
    logic       enter, finish, clear;
    logic [9:0] A;
    logic       valid, err;
    logic [1:0] dig_cnt;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    bit chk_on = 1'b0;

    int m_digits[$];
    bit m_err, m_active, m_valid;
    int m_A;

    bcd_entry_to_bin #(.N(10), .MAX_DIG(3)) dut (
        .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .enter(enter),
        .finish(finish), .clear(clear), .A(A), .valid(valid), .err(err), .dig_cnt(dig_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int qval();
        int v = 0;
        foreach (m_digits[i]) v = v * 10 + m_digits[i];
        return v;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_err = 0; m_active = 0; m_valid = 0; m_A = 0;
    endtask

    // Number-entry semantics: clear wins, then enter, then finish.
    task automatic model_apply(input bit e, input bit f, input bit c, input int d);
        if (c) begin
            m_digits.delete();
            m_err = 0; m_active = 0;
        end else if (e) begin
            if (m_err) begin
            end else if (d > 9) begin
                m_err = 1;
            end else begin
                if (!m_active) begin
                    m_digits.delete();
                    m_active = 1;
                end
                m_digits.push_back(d);
                if (m_digits.size() == 3) begin
                    m_A = qval(); m_valid = 1; m_active = 0;
                end
            end
        end else if (f) begin
            if (m_active && !m_err) begin
                m_A = qval(); m_valid = 1; m_active = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("A", int'(A), m_A);
            chk("dig_cnt", int'(dig_cnt), m_digits.size());
            chk("err", int'(err), int'(m_err));
            chk("valid", int'(valid), int'(m_valid));
            if (valid) vcount++;
        end
    end

    task automatic press_multi(input bit e, input bit f, input bit c, input int d);
        @(negedge clk);
        digit_in = 4'(d);
        enter = e; finish = f; clear = c;
        repeat (3) @(posedge clk);
        #1 model_apply(e, f, c, d);
        @(posedge clk);
        #1 m_valid = 0;
        @(negedge clk);
        enter = 0; finish = 0; clear = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input int d);
        press_multi(1, 0, 0, d);
    endtask

    task automatic fin();
        press_multi(0, 1, 0, 0);
    endtask

    task automatic clr();
        press_multi(0, 0, 1, 0);
    endtask

    initial begin
        rst_n = 0; digit_in = 0; enter = 0; finish = 0; clear = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_A", int'(A), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_cnt", int'(dig_cnt), 0);
        @(negedge clk);
        rst_n = 1;
        chk_on = 1;
        repeat (6) @(negedge clk);

        press(4); press(0); press(7);
        chk("lit_407_A", int'(A), 407);
        chk("lit_407_cnt", int'(dig_cnt), 3);
        chk("lit_407_pulses", vcount, 1);

        press(9); press(9); press(9);
        chk("lit_999_A", int'(A), 999);
        press(1);
        chk("lit_after999_cnt", int'(dig_cnt), 1);
        chk("lit_after999_A", int'(A), 999);

        clr();
        fin();
        chk("lit_idle_finish_A", int'(A), 999);
        press(2); press(5); fin();
        chk("lit_25_A", int'(A), 25);
        chk("lit_25_pulses", vcount, 3);
        fin();
        chk("lit_25_again_A", int'(A), 25);
        chk("lit_25_again_pulses", vcount, 3);

        press(3); press(12);
        chk("lit_err_set", int'(err), 1);
        chk("lit_err_A", int'(A), 25);
        press(4);
        chk("lit_err_ignore_cnt", int'(dig_cnt), 1);
        clr();
        chk("lit_err_clr", int'(err), 0);
        chk("lit_err_clr_cnt", int'(dig_cnt), 0);

        press_multi(1, 0, 1, 6);
        chk("lit_enter_clear_cnt", int'(dig_cnt), 0);

        press(1);
        press_multi(1, 1, 0, 2);
        chk("lit_enter_finish_cnt", int'(dig_cnt), 2);
        fin();
        chk("lit_12_A", int'(A), 12);

        press(8); press(1);
        @(negedge clk);
        #2 rst_n = 0;
        model_reset();
        enter = 1;
        digit_in = 4'd5;
        #1;
        chk("lit_async_A", int'(A), 0);
        chk("lit_async_cnt", int'(dig_cnt), 0);
        chk("lit_async_valid", int'(valid), 0);
        chk("lit_async_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (10) @(negedge clk);
        chk("lit_held_enter_cnt", int'(dig_cnt), 0);
        enter = 0;
        repeat (4) @(negedge clk);

        press(5); fin();
        chk("lit_5_A", int'(A), 5);

        repeat (3) @(negedge clk);
        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
